// File: rtl/core_alu_arbiter_if.sv
// Handshake bundle between the core array, the ALU-input arbiter and the ALU.
// The arbiter uses the slave modport; the cores and ALU side use master.
interface core_alu_arbiter_if #(
  parameter int unsigned NUM_CORES = 9,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4
);
  logic [NUM_CORES-1:0]        req_valid;
  logic [NUM_CORES*DATA_W-1:0] req_data;
  logic [NUM_CORES-1:0]        req_ready;
  logic                        alu_valid;
  logic [DATA_W-1:0]           alu_data;
  logic [ID_W-1:0]             alu_src;
  logic                        alu_ready;

  modport master (
    output req_valid, req_data, alu_ready,
    input  req_ready, alu_valid, alu_data, alu_src
  );

  modport slave (
    input  req_valid, req_data, alu_ready,
    output req_ready, alu_valid, alu_data, alu_src
  );
endinterface

// File: rtl/core_alu_arbiter.sv
// Round-robin arbiter plus one-entry output buffer feeding the shared ALU port.
// Optional macro CORE_ALU_ARB_PROB_PRIORITY_EN favours the probabilistic core (id NUM_CORES-1).
module core_alu_arbiter #(
  parameter int unsigned NUM_CORES = 9,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  core_alu_arbiter_if.slave bus,
  output logic [15:0]       grant_total
);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CORES - 1);

  logic [ID_W-1:0]      r_ptr;
  logic [DATA_W-1:0]    r_data;
  logic [ID_W-1:0]      r_src;
  logic                 r_valid;
  logic [15:0]          r_grants;

  logic                 w_slot_free;
  logic                 w_found_hi;
  logic                 w_found_lo;
  logic                 w_xfer;
  logic [ID_W-1:0]      w_cand_hi;
  logic [ID_W-1:0]      w_cand_lo;
  logic [ID_W-1:0]      w_rr_cand;
  logic [ID_W-1:0]      w_cand;
  logic [NUM_CORES-1:0] w_ready;
  logic [DATA_W-1:0]    w_data;

  assign w_slot_free = !r_valid || bus.alu_ready;

  // Wrapping search as two passes: first requester at/above ptr, else lowest requester.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_cand_hi  = '0;
    w_cand_lo  = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (bus.req_valid[i]) begin
        if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_cand_lo  = ID_W'(i);
        end
        if (!w_found_hi && (ID_W'(i) >= r_ptr)) begin
          w_found_hi = 1'b1;
          w_cand_hi  = ID_W'(i);
        end
      end
    end
    w_rr_cand = w_found_hi ? w_cand_hi : w_cand_lo;
  end

`ifdef CORE_ALU_ARB_PROB_PRIORITY_EN
  logic r_last_prob;
  logic w_others;

  assign w_others = |bus.req_valid[NUM_CORES-2:0];
  // Probabilistic core wins unless it won the previous transfer and someone else is waiting.
  assign w_cand   = (bus.req_valid[NUM_CORES-1] && !(r_last_prob && w_others)) ? LAST_ID
                                                                               : w_rr_cand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_prob <= 1'b0;
    end else if (w_xfer) begin
      r_last_prob <= (w_cand == LAST_ID);
    end
  end
`else
  assign w_cand = w_rr_cand;
`endif

  always_comb begin
    w_ready = '0;
    w_data  = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (w_cand == ID_W'(i)) begin
        w_ready[i] = rst && w_slot_free && w_found_lo;
        w_data     = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_xfer = |w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_src    <= '0;
      r_ptr    <= '0;
      r_grants <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_src   <= w_cand;
      r_ptr   <= (w_cand == LAST_ID) ? '0 : w_cand + ID_W'(1);
      if (r_grants != '1) begin
        r_grants <= r_grants + 16'd1;
      end
    end else if (bus.alu_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.alu_valid = r_valid;
  assign bus.alu_data  = r_data;
  assign bus.alu_src   = r_src;
  assign grant_total   = r_grants;
endmodule

// File: tb/tb_core_alu_arbiter.sv
// Scoreboard bench for core_alu_arbiter: expected {src,data} pushed at grant, popped after the edge.
module tb_core_alu_arbiter;
  localparam int unsigned NC = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] grant_total;

  core_alu_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW), .ID_W(IW)) bus ();

  core_alu_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .grant_total (grant_total)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } item_t;

  item_t       sb[$];
  item_t       e;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_grants = 0;

  function automatic logic [DW-1:0] cdata(int unsigned k);
    return 32'hA500_0000 | (32'(k) << 8) | 32'(k);
  endfunction

  function automatic logic [NC-1:0] oh(int unsigned k);
    logic [NC-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] exp_total();
    return (exp_grants > 65535) ? 16'hFFFF : 16'(exp_grants);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int unsigned k, logic [DW-1:0] d);
    sb.push_back(item_t'({IW'(k), d}));
    exp_grants++;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.alu_ready = 1'b0;
    sb.delete();
    exp_grants = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < NC; i++) bus.req_data[i*DW +: DW] = cdata(i);
    rst           = 1'b0;
    bus.req_valid = '1;
    bus.alu_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.alu_valid !== 1'b0) begin n_errors++; $display("FAIL reset_alu_valid: got %b expected 0", bus.alu_valid); end
    n_checks++;
    if (bus.alu_data !== '0) begin n_errors++; $display("FAIL reset_alu_data: got %h expected 0", bus.alu_data); end
    n_checks++;
    if (bus.alu_src !== '0) begin n_errors++; $display("FAIL reset_alu_src: got %0d expected 0", bus.alu_src); end
    n_checks++;
    if (bus.req_ready !== '0) begin n_errors++; $display("FAIL reset_req_ready: got %h expected 0", bus.req_ready); end
    n_checks++;
    if (grant_total !== 16'd0) begin n_errors++; $display("FAIL reset_grant_total: got %0d expected 0", grant_total); end
    bus.req_valid = '0;
    rst           = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.req_valid               = 9'h008;
    bus.req_data[3*DW +: DW]    = 32'hDEADBEEF;
    bus.alu_ready               = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 9'h008) begin n_errors++; $display("FAIL single_req_ready: got %h expected 008", bus.req_ready); end
    push_exp(3, 32'hDEADBEEF);
    tick();
    bus.req_valid = '0;
    e = sb.pop_front();
    n_checks++;
    if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, e.id, e.data}) begin
      n_errors++;
      $display("FAIL single_out: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
               bus.alu_valid, bus.alu_src, bus.alu_data, e.id, e.data);
    end
    n_checks++;
    if (grant_total !== exp_total()) begin n_errors++; $display("FAIL single_grant_total: got %0d expected %0d", grant_total, exp_total()); end
    tick();
    n_checks++;
    if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b0, 4'd3, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL single_drain: got v=%b src=%0d data=%h expected v=0 src=3 data=deadbeef",
               bus.alu_valid, bus.alu_src, bus.alu_data);
    end
    bus.req_data[3*DW +: DW] = cdata(3);
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid = '1;
    bus.alu_ready = 1'b1;
    for (int unsigned k = 0; k < 11; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== oh(k % NC)) begin
        n_errors++;
        $display("FAIL rr_req_ready[%0d]: got %h expected %h", k, bus.req_ready, oh(k % NC));
      end
      push_exp(k % NC, cdata(k % NC));
      tick();
      if (k == 10) bus.req_valid = '0;
      e = sb.pop_front();
      n_checks++;
      if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, e.id, e.data}) begin
        n_errors++;
        $display("FAIL rr_out[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                 k, bus.alu_valid, bus.alu_src, bus.alu_data, e.id, e.data);
      end
    end
    #1;
    n_checks++;
    if (bus.req_ready !== '0) begin n_errors++; $display("FAIL rr_idle_ready: got %h expected 0", bus.req_ready); end
    tick();
    n_checks++;
    if (bus.alu_valid !== 1'b0) begin n_errors++; $display("FAIL rr_drain: got %b expected 0", bus.alu_valid); end
    n_checks++;
    if (grant_total !== exp_total()) begin n_errors++; $display("FAIL rr_grant_total: got %0d expected %0d", grant_total, exp_total()); end
  endtask

  task automatic test_backpressure();
    item_t held;
    do_reset();
    bus.req_valid = oh(5);
    bus.alu_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== oh(5)) begin n_errors++; $display("FAIL bp_first_ready: got %h expected %h", bus.req_ready, oh(5)); end
    push_exp(5, cdata(5));
    tick();
    bus.req_valid = oh(6) | oh(2);
    held = sb.pop_front();
    n_checks++;
    if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, held.id, held.data}) begin
      n_errors++;
      $display("FAIL bp_load: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
               bus.alu_valid, bus.alu_src, bus.alu_data, held.id, held.data);
    end
    for (int unsigned c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== '0) begin n_errors++; $display("FAIL bp_stall_ready[%0d]: got %h expected 0", c, bus.req_ready); end
      tick();
      n_checks++;
      if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, held.id, held.data}) begin
        n_errors++;
        $display("FAIL bp_stall_out[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                 c, bus.alu_valid, bus.alu_src, bus.alu_data, held.id, held.data);
      end
    end
    bus.alu_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== oh(6)) begin n_errors++; $display("FAIL bp_release_ready: got %h expected %h", bus.req_ready, oh(6)); end
    push_exp(6, cdata(6));
    tick();
    bus.req_valid = '0;
    e = sb.pop_front();
    n_checks++;
    if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, e.id, e.data}) begin
      n_errors++;
      $display("FAIL bp_refill: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
               bus.alu_valid, bus.alu_src, bus.alu_data, e.id, e.data);
    end
    tick();
  endtask

  task automatic test_prob_pair();
    int unsigned seq[4];
`ifdef CORE_ALU_ARB_PROB_PRIORITY_EN
    seq = '{8, 2, 8, 2};
`else
    seq = '{2, 8, 2, 8};
`endif
    do_reset();
    bus.req_valid = oh(2) | oh(8);
    bus.alu_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      push_exp(seq[k], cdata(seq[k]));
      tick();
      if (k == 3) bus.req_valid = '0;
      e = sb.pop_front();
      n_checks++;
      if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, e.id, e.data}) begin
        n_errors++;
        $display("FAIL pair_out[%0d]: got v=%b src=%0d expected v=1 src=%0d",
                 k, bus.alu_valid, bus.alu_src, e.id);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = oh(4);
    bus.alu_ready = 1'b0;
    tick();
    bus.req_valid = oh(3) | oh(6);
    n_checks++;
    if ({bus.alu_valid, bus.alu_src} !== {1'b1, 4'd4}) begin
      n_errors++;
      $display("FAIL mid_load: got v=%b src=%0d expected v=1 src=4", bus.alu_valid, bus.alu_src);
    end
    rst = 1'b0;
    exp_grants = 0;
    #1;
    n_checks++;
    if (bus.alu_valid !== 1'b0) begin n_errors++; $display("FAIL mid_async_valid: got %b expected 0", bus.alu_valid); end
    n_checks++;
    if (bus.req_ready !== '0) begin n_errors++; $display("FAIL mid_reset_ready: got %h expected 0", bus.req_ready); end
    tick();
    rst           = 1'b1;
    bus.alu_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== oh(3)) begin n_errors++; $display("FAIL mid_restart_ready: got %h expected %h", bus.req_ready, oh(3)); end
    push_exp(3, cdata(3));
    tick();
    bus.req_valid = '0;
    e = sb.pop_front();
    n_checks++;
    if ({bus.alu_valid, bus.alu_src, bus.alu_data} !== {1'b1, e.id, e.data}) begin
      n_errors++;
      $display("FAIL mid_restart_out: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
               bus.alu_valid, bus.alu_src, bus.alu_data, e.id, e.data);
    end
    n_checks++;
    if (grant_total !== exp_total()) begin n_errors++; $display("FAIL mid_grant_total: got %0d expected %0d", grant_total, exp_total()); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.req_valid = '1;
    bus.alu_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    exp_grants = 65534;
    n_checks++;
    if (grant_total !== exp_total()) begin n_errors++; $display("FAIL sat_below: got %h expected %h", grant_total, exp_total()); end
    repeat (6) @(posedge clk);
    #1;
    exp_grants = 65540;
    n_checks++;
    if (grant_total !== exp_total()) begin n_errors++; $display("FAIL sat_hold: got %h expected %h", grant_total, exp_total()); end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.alu_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_prob_pair();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/core_alu_arbiter.md
# core_alu_arbiter

Round-robin arbiter and one-entry output buffer that shares the single ALU input port between the nine processor cores: eight standard cores (ids 0–7) and the probabilistic core (id 8). Each core presents a result with a valid/ready handshake. The arbiter selects one core per cycle, registers its data together with the source id, and holds it until the ALU accepts it. It sits between the core array and the ALU, and also provides a saturating grant counter for debug.

## Interface
- `NUM_CORES`, 9, number of requesting cores; ids 0..NUM_CORES-1, with id NUM_CORES-1 being the probabilistic core
- `DATA_W`, 32, result width
- `ID_W`, 4, width of the source id; must satisfy `2**ID_W >= NUM_CORES`
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_CORES  per-core request; bit i belongs to core i
- `req_data`  in  NUM_CORES*DATA_W  per-core data; core i occupies bits `[i*DATA_W +: DATA_W]`
- `req_ready`  out  NUM_CORES  per-core accept, one-hot or zero
- `alu_valid`  out  1  buffered item available to the ALU
- `alu_data`  out  DATA_W  buffered data
- `alu_src`  out  ID_W  core id of the buffered data
- `alu_ready`  in  1  ALU accepts the buffered item
- `grant_total`  out  16  saturating count of accepted requests

## Operation
- Transfers:
  - A core transfer occurs when `req_valid[i] && req_ready[i]`.
  - An ALU transfer occurs when `alu_valid && alu_ready`.
- Slot: a single output register. `slot_free = !alu_valid || alu_ready`.
- Grant (combinational):
  - Candidate = first i with `req_valid[i]`, searching from `ptr` upward and wrapping from NUM_CORES-1 to 0.
  - `req_ready` = onehot(candidate) when `slot_free` and any request is present; otherwise 0.
  - `req_ready` never depends on the ALU except through `alu_ready` in `slot_free`.
- On a core transfer from core k:
  - `alu_data <= req_data[k]`, `alu_src <= k`, `alu_valid <= 1`.
  - `ptr <= (k == NUM_CORES-1) ? 0 : k+1`.
  - `grant_total` increments, saturating at 0xFFFF.
- On an ALU transfer with no simultaneous core transfer: `alu_valid <= 0`. `alu_data` and `alu_src` keep their last value.
- Simultaneous ALU and core transfer in the same cycle: the slot is drained and refilled. `alu_valid` stays 1 and the new data appears next cycle, so there is no bubble.
- While `alu_valid && !alu_ready`:
  - `alu_data` and `alu_src` are stable.
  - All `req_ready` are 0.
- Cores must hold `req_valid` and `req_data` until accepted. The arbiter does not rely on this: a dropped request simply loses eligibility.
- `ptr` changes only on a core transfer. Idle cycles do not rotate it.

## Timing
- Reset values (asynchronous assertion, synchronous-to-clock deassertion handled upstream):
  - `alu_valid` = 0, `alu_data` = 0, `alu_src` = 0, `ptr` = 0, `grant_total` = 0.
  - `req_ready` = 0 throughout reset.
- Latency: 1 cycle from core transfer to `alu_valid`/`alu_data` visible.
- Throughput: 1 item per cycle when `alu_ready` is held high.
- Reset asserted mid-operation: the buffered item is discarded, no transfer completes in that cycle, and arbitration restarts at core 0.
- No request present: `req_ready` = 0 and the state holds.

## Configuration
- `CORE_ALU_ARB_PROB_PRIORITY_EN` defined:
  - Core NUM_CORES-1 is granted whenever it requests, unless the previous core transfer was also from core NUM_CORES-1 and another core requests.
  - In that case the normal round-robin candidate is granted, so the probabilistic core is limited to at most every other slot under contention.
  - The `ptr` update rule is unchanged. One extra register holds last-grant-was-probabilistic; it resets to 0.
- Macro undefined: pure round robin as above, and the extra register is absent.

## Test plan
- Only core 3 requests with `req_data` = 0xDEADBEEF; `alu_ready` = 1 → `req_ready` = 0x008 in the same cycle; next cycle `alu_valid` = 1, `alu_data` = 0xDEADBEEF, `alu_src` = 3; `grant_total` = 1.
- All 9 cores request continuously with `alu_ready` = 1, macro undefined → `alu_src` sequence 0,1,…,8,0,1 on consecutive cycles, with no bubbles.
- Buffered item from core 5, then `alu_ready` = 0 for 5 cycles → `alu_data` and `alu_src` stable and `req_ready` = 0 throughout; on release, drain and refill in the same cycle and the next grant is core 6 (if requesting).
- Cores 2 and 8 requesting continuously from reset: macro undefined → grants 2,8,2,8; macro defined → 8,2,8,2.
- Reset pulsed while `alu_valid` = 1 with `alu_ready` = 0 → `alu_valid` drops to 0 immediately; the first grant after release goes to the lowest-numbered requesting core.
- Force 65540 accepted transfers → `grant_total` stays at 0xFFFF.
